// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// x0 reads as zero and is never written. Reads and optional write bypass are combinational.
module regfile_mp_sb_rd #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]               addr,
    input  logic [NREGS-1:0][XLEN-1:0]  src,
    input  logic [NREGS-1:0]            busy_q,
    input  logic [NREGS-1:0]            wr_hit,
    output logic [XLEN-1:0]             data,
    output logic                        busy
);
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (addr != '0) begin
            data = src[addr];
            busy = busy_q[addr] & ~wr_hit[addr];
        end
    end
endmodule

module regfile_mp_sb #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 flush
);
    logic [NREGS-1:0][XLEN-1:0] regs_q, wr_val, rd_src;
    logic [NREGS-1:0]           busy_q, busy_d, wr_hit, rd_hit;

    // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
    always_comb begin
        wr_hit = '0;
        wr_val = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                wr_val[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Writeback clears, issue re-sets (new producer), flush clears everything.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (iss_en && iss_rd != '0)
            busy_d[iss_rd] = 1'b1;
        if (flush)
            busy_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= wr_val;
            busy_q <= busy_d;
        end
    end

    assign rd_src = BYPASS ? wr_val : regs_q;
    assign rd_hit = BYPASS ? wr_hit : '0;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_mp_sb_rd #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rd (
            .addr   (rd_addr[i*AW +: AW]),
            .src    (rd_src),
            .busy_q (busy_q),
            .wr_hit (rd_hit),
            .data   (rd_data[i*XLEN +: XLEN]),
            .busy   (rd_busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: default 2R/2W bypass file plus a 4R/1W/16-reg non-bypass file.
module tb_regfile_mp_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut A: defaults (XLEN=64, NREGS=32, NRD=2, NWR=2, BYPASS=1)
    logic [9:0]   a_rd_addr;
    logic [127:0] a_rd_data;
    logic [1:0]   a_rd_busy;
    logic [1:0]   a_wr_en;
    logic [9:0]   a_wr_addr;
    logic [127:0] a_wr_data;
    logic         a_iss_en, a_flush;
    logic [4:0]   a_iss_rd;

    // dut B: NREGS=16, NRD=4, NWR=1, BYPASS=0
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [0:0]   b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_iss_en, b_flush;
    logic [3:0]   b_iss_rd;

    regfile_mp_sb u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_rd(a_iss_rd), .flush(a_flush)
    );

    regfile_mp_sb #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(1), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_rd(b_iss_rd), .flush(b_flush)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_wr_en = '0; a_iss_en = 1'b0; a_flush = 1'b0; a_iss_rd = '0;
        b_wr_en = '0; b_iss_en = 1'b0; b_flush = 1'b0; b_iss_rd = '0;
    endtask

    task automatic a_wr(input int p, input logic [4:0] ad, input logic [63:0] d);
        a_wr_en[p] = 1'b1;
        a_wr_addr[p*5 +: 5] = ad;
        a_wr_data[p*64 +: 64] = d;
    endtask

    task automatic a_rd(input int p, input logic [4:0] ad);
        a_rd_addr[p*5 +: 5] = ad;
    endtask

    task automatic a_iss(input logic [4:0] r);
        a_iss_en = 1'b1;
        a_iss_rd = r;
    endtask

    task automatic a_chk(input string tag, input int p, input logic [4:0] ad,
                         input logic [63:0] d, input logic bz);
        a_rd(p, ad);
        #1;
        chk({tag, "_data"}, a_rd_data[p*64 +: 64], d);
        chk({tag, "_busy"}, {63'd0, a_rd_busy[p]}, {63'd0, bz});
    endtask

    task automatic b_chk(input string tag, input int p, input logic [3:0] ad,
                         input logic [63:0] d, input logic bz);
        b_rd_addr[p*4 +: 4] = ad;
        #1;
        chk({tag, "_data"}, b_rd_data[p*64 +: 64], d);
        chk({tag, "_busy"}, {63'd0, b_rd_busy[p]}, {63'd0, bz});
    endtask

    initial begin
        a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0;
        b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
        idle();

        // reset state: every address on every port reads 0, not busy
        @(negedge clk);
        for (int r = 0; r < 32; r++) begin
            a_rd(0, r[4:0]); a_rd(1, 5'(31 - r));
            #1;
            chk("rst_a_data", (a_rd_data[63:0] | a_rd_data[127:64]), 64'd0);
            chk("rst_a_busy", {62'd0, a_rd_busy}, 64'd0);
        end
        for (int r = 0; r < 16; r++) begin
            for (int p = 0; p < 4; p++) b_rd_addr[p*4 +: 4] = 4'(r + p);
            #1;
            chk("rst_b_data", b_rd_data[63:0] | b_rd_data[127:64] | b_rd_data[191:128] | b_rd_data[255:192], 64'd0);
            chk("rst_b_busy", {60'd0, b_rd_busy}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // x0 writes are dropped, including bypass
        a_wr(0, 5'd0, 64'hDEAD); a_wr(1, 5'd0, 64'hBEEF); a_iss(5'd0);
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'hDEAD;
        a_chk("x0_byp", 0, 5'd0, 64'd0, 1'b0);
        tick(); idle();
        a_chk("x0_a", 1, 5'd0, 64'd0, 1'b0);
        b_chk("x0_b", 0, 4'd0, 64'd0, 1'b0);

        // write conflict: highest port wins; other-address lower port still commits
        a_wr(0, 5'd5, 64'h1111); a_wr(1, 5'd5, 64'h2222);
        a_chk("conf_byp", 0, 5'd5, 64'h2222, 1'b0);
        tick(); idle();
        a_chk("conf_q", 1, 5'd5, 64'h2222, 1'b0);
        a_wr(0, 5'd6, 64'h6666); a_wr(1, 5'd7, 64'h7777);
        tick(); idle();
        a_chk("split_p0", 0, 5'd6, 64'h6666, 1'b0);
        a_chk("split_p1", 1, 5'd7, 64'h7777, 1'b0);

        // BYPASS=0: write visible one cycle later
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 64'h1234;
        tick(); idle();
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 64'hABCD;
        b_chk("nob_old", 2, 4'd7, 64'h1234, 1'b0);
        tick(); idle();
        b_chk("nob_new", 3, 4'd7, 64'hABCD, 1'b0);
        b_iss_en = 1'b1; b_iss_rd = 4'd3;
        tick(); idle();
        b_chk("nob_set", 1, 4'd3, 64'd0, 1'b1);
        b_wr_en = 1'b1; b_wr_addr = 4'd3; b_wr_data = 64'h33;
        b_chk("nob_busy_hold", 1, 4'd3, 64'd0, 1'b1);
        tick(); idle();
        b_chk("nob_clr", 1, 4'd3, 64'h33, 1'b0);

        // busy set, bypass-masked clear, set-wins
        a_iss(5'd9);
        tick(); idle();
        a_chk("busy_set", 0, 5'd9, 64'd0, 1'b1);
        a_wr(0, 5'd9, 64'h55);
        a_chk("busy_byp", 0, 5'd9, 64'h55, 1'b0);
        tick(); idle();
        a_chk("busy_clr", 1, 5'd9, 64'h55, 1'b0);
        a_wr(1, 5'd9, 64'h56); a_iss(5'd9);
        tick(); idle();
        a_chk("set_wins", 0, 5'd9, 64'h56, 1'b1);

        // flush beats issue; write in flush cycle commits
        a_iss(5'd3); tick(); a_iss(5'd4); tick(); a_iss(5'd5); tick(); idle();
        a_chk("pre_fl3", 0, 5'd3, 64'd0, 1'b1);
        a_chk("pre_fl4", 1, 5'd4, 64'd0, 1'b1);
        a_flush = 1'b1; a_iss(5'd6); a_wr(1, 5'd3, 64'h3333);
        tick(); idle();
        a_chk("fl_x3", 0, 5'd3, 64'h3333, 1'b0);
        a_chk("fl_x4", 1, 5'd4, 64'd0, 1'b0);
        a_chk("fl_x5", 0, 5'd5, 64'h2222, 1'b0);
        a_chk("fl_x6", 1, 5'd6, 64'h6666, 1'b0);
        a_chk("fl_x9", 0, 5'd9, 64'h56, 1'b0);

        // async reset mid-operation, then release-cycle edge behaves normally
        a_wr(0, 5'd10, 64'hFF); tick(); idle();
        a_iss(5'd11); tick(); idle();
        a_chk("pre_rst10", 0, 5'd10, 64'hFF, 1'b0);
        a_chk("pre_rst11", 1, 5'd11, 64'd0, 1'b1);
        #1 rst_n = 1'b0;
        a_chk("rst_x10", 0, 5'd10, 64'd0, 1'b0);
        a_chk("rst_x11", 1, 5'd11, 64'd0, 1'b0);
        b_chk("rst_b7", 0, 4'd7, 64'd0, 1'b0);
        a_wr(0, 5'd12, 64'h12); a_iss(5'd12);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); idle();
        a_chk("rel_x12", 0, 5'd12, 64'h12, 1'b1);
        a_chk("rel_x10", 1, 5'd10, 64'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
